// File: rtl/ahblite_led_sequencer.sv
// AHB-Lite zero-wait-state slave that drives an 8-bit LED port from a manual
// register or by stepping through a four-entry pattern table at a set period.
module ahblite_led_sequencer (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic [3:0]  HPROT,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        HRESP,
  output logic [7:0]  led_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Address-phase capture
  logic        dp_valid_q, dp_valid_d;
  logic        dp_write_q, dp_write_d;
  logic [2:0]  dp_addr_q,  dp_addr_d;

  // Software-visible registers
  logic        ctrl_en_q,   ctrl_en_d;
  logic        ctrl_loop_q, ctrl_loop_d;
  logic [1:0]  ctrl_last_q, ctrl_last_d;
  logic [23:0] period_q,    period_d;
  logic [7:0]  manual_q,    manual_d;
  logic [3:0][7:0] pat_q,   pat_d;

  // Sequencer state
  state_t      state_q, state_d;
  logic [23:0] cnt_q,   cnt_d;
  logic [1:0]  idx_q,   idx_d;
  logic [7:0]  led_q,   led_d;

  logic        wr_en;
  logic        ctrl_wr;
  logic [23:0] period_eff;
  logic        step_expired;
  logic [1:0]  idx_inc;

  logic unused_bits;
  assign unused_bits = ^{HSIZE, HPROT, HADDR[31:5], HADDR[1:0], HTRANS[0], HWDATA[31:24]};

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign led_out   = led_q;

  assign dp_valid_d = HSEL & HTRANS[1] & HREADY;
  assign dp_write_d = HWRITE;
  assign dp_addr_d  = HADDR[4:2];

  assign wr_en   = dp_valid_q & dp_write_q;
  assign ctrl_wr = wr_en && (dp_addr_q == 3'd0);

  always_comb begin
    ctrl_en_d   = ctrl_en_q;
    ctrl_loop_d = ctrl_loop_q;
    ctrl_last_d = ctrl_last_q;
    period_d    = period_q;
    manual_d    = manual_q;
    if (ctrl_wr) begin
      ctrl_en_d   = HWDATA[0];
      ctrl_loop_d = HWDATA[1];
      ctrl_last_d = HWDATA[3:2];
    end
    if (wr_en && dp_addr_q == 3'd1) period_d = HWDATA[23:0];
    if (wr_en && dp_addr_q == 3'd3) manual_d = HWDATA[7:0];
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_pat
    assign pat_d[gi] = (wr_en && dp_addr_q == 3'(gi + 4)) ? HWDATA[7:0] : pat_q[gi];
  end

  assign period_eff   = (period_q == 24'd0) ? 24'd1 : period_q;
  assign step_expired = (cnt_q == period_eff - 24'd1);
  assign idx_inc      = idx_q + 2'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    led_d   = led_q;
    case (state_q)
      S_IDLE: led_d = manual_d;
      S_RUN: begin
        if (step_expired) begin
          cnt_d = 24'd0;
          if (idx_q == ctrl_last_q) begin
            if (ctrl_loop_q) begin
              idx_d = 2'd0;
              led_d = pat_q[0];
            end else begin
              state_d = S_DONE;
            end
          end else begin
            idx_d = idx_inc;
            led_d = pat_q[idx_inc];
          end
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      S_DONE: ;
      default: state_d = S_IDLE;
    endcase
    // A CTRL write overrides whatever the step logic decided this cycle.
    if (ctrl_wr) begin
      if (HWDATA[0]) begin
        if (state_q != S_RUN) begin
          state_d = S_RUN;
          cnt_d   = 24'd0;
          idx_d   = 2'd0;
          led_d   = pat_q[0];
        end
      end else begin
        state_d = S_IDLE;
        cnt_d   = 24'd0;
        idx_d   = 2'd0;
        led_d   = manual_d;
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dp_valid_q  <= 1'b0;
      dp_write_q  <= 1'b0;
      dp_addr_q   <= 3'd0;
      ctrl_en_q   <= 1'b0;
      ctrl_loop_q <= 1'b0;
      ctrl_last_q <= 2'd0;
      period_q    <= 24'd1;
      manual_q    <= 8'd0;
      pat_q       <= '0;
      state_q     <= S_IDLE;
      cnt_q       <= 24'd0;
      idx_q       <= 2'd0;
      led_q       <= 8'd0;
    end else begin
      dp_valid_q  <= dp_valid_d;
      dp_write_q  <= dp_write_d;
      dp_addr_q   <= dp_addr_d;
      ctrl_en_q   <= ctrl_en_d;
      ctrl_loop_q <= ctrl_loop_d;
      ctrl_last_q <= ctrl_last_d;
      period_q    <= period_d;
      manual_q    <= manual_d;
      pat_q       <= pat_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      led_q       <= led_d;
    end
  end

  // Read mux driven from the registered data-phase address.
  always_comb begin
    HRDATA = 32'd0;
    if (dp_valid_q && !dp_write_q) begin
      case (dp_addr_q)
        3'd0: HRDATA = {28'd0, ctrl_last_q, ctrl_loop_q, ctrl_en_q};
        3'd1: HRDATA = {8'd0, period_q};
        3'd2: HRDATA = {28'd0, state_q == S_DONE, idx_q, state_q == S_RUN};
        3'd3: HRDATA = {24'd0, manual_q};
        default: HRDATA = {24'd0, pat_q[dp_addr_q[1:0]]};
      endcase
    end
  end

endmodule

// File: tb/tb_ahblite_led_sequencer.sv
// Randomized self-checking bench for ahblite_led_sequencer; expected LED and
// STATUS values come from a step-count model of the playback rules.
module tb_ahblite_led_sequencer;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [3:0]  HPROT;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        HRESP;
  logic [7:0]  led_out;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0] pat_m [4];
  logic [7:0] manual_m;
  int         start_cyc;

  ahblite_led_sequencer dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HPROT(HPROT), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP), .led_out(led_out)
  );

  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc <= cyc + 1;

  // Table index shown j cycles after playback started.
  function automatic int model_idx(int j, int p, int last, bit loop);
    int k;
    k = j / p;
    if (loop) return k % (last + 1);
    if (k > last) return last;
    return k;
  endfunction

  function automatic bit model_done(int j, int p, int last, bit loop);
    return !loop && (j / p) > last;
  endfunction

  function automatic logic [31:0] model_status(int j, int p, int last, bit loop);
    logic [31:0] s;
    logic [1:0]  ix;
    ix = 2'(model_idx(j, p, last, loop));
    s  = 32'd0;
    if (model_done(j, p, last, loop)) s[3] = 1'b1;
    else s[0] = 1'b1;
    s[2:1] = ix;
    return s;
  endfunction

  task automatic bus_write(input logic [4:0] off, input logic [31:0] data);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1;
    HADDR = {27'($urandom), off};
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
    HADDR = $urandom; HWDATA = data;
    @(posedge HCLK); #1;
    HWDATA = $urandom;
    $display("wr off=0x%02h data=0x%08h", off, data);
  endtask

  task automatic bus_read(input logic [4:0] off, output logic [31:0] data, output int rcyc);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0;
    HADDR = {27'($urandom), off};
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    data = HRDATA;
    rcyc = cyc;
    @(posedge HCLK); #1;
    $display("rd off=0x%02h data=0x%08h", off, data);
  endtask

  task automatic start_seq(input int period, input int last, input bit loop);
    bus_write(5'h00, 32'h0);
    bus_write(5'h04, 32'(period));
    bus_write(5'h00, {28'd0, 2'(last), loop, 1'b1});
    start_cyc = cyc;
  endtask

  task automatic test_reset;
    logic [31:0] rd;
    int rc;
    HRESET = 1'b1;
    repeat (2) @(posedge HCLK);
    #1;
    checks++;
    if (led_out !== 8'h00 || HRDATA !== 32'h0 || HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs led=%h rdata=%h ready=%b resp=%b want 00/0/1/0",
               led_out, HRDATA, HREADYOUT, HRESP);
    end
    HRESET = 1'b0;
    @(posedge HCLK); #1;
    bus_read(5'h00, rd, rc);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL reset_ctrl got=%h want=0", rd); end
    bus_read(5'h04, rd, rc);
    checks++;
    if (rd !== 32'h1) begin errors++; $display("FAIL reset_period got=%h want=1", rd); end
    bus_read(5'h08, rd, rc);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL reset_status got=%h want=0", rd); end
    for (int i = 0; i < 4; i++) begin
      bus_read(5'(5'h10 + 4 * i), rd, rc);
      checks++;
      if (rd !== 32'h0) begin errors++; $display("FAIL reset_pat%0d got=%h want=0", i, rd); end
      pat_m[i] = 8'h00;
    end
    manual_m = 8'h00;
  endtask

  task automatic test_manual;
    logic [31:0] rd;
    logic [7:0]  v;
    int rc;
    for (int i = 0; i < 5; i++) begin
      v = (i == 0) ? 8'hA5 : 8'($urandom);
      bus_write(5'h0C, {24'($urandom), v});
      manual_m = v;
      checks++;
      if (led_out !== v) begin errors++; $display("FAIL manual_led got=%h want=%h", led_out, v); end
      bus_read(5'h0C, rd, rc);
      checks++;
      if (rd !== {24'd0, v}) begin errors++; $display("FAIL manual_read got=%h want=%h", rd, v); end
    end
    // Unselected and IDLE-type transfers must not write.
    HSEL = 1'b0; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h0C;
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b00; HWDATA = 32'h5A;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HWRITE = 1'b0; HWDATA = 32'h3C;
    @(posedge HCLK); #1;
    checks++;
    if (led_out !== manual_m) begin errors++; $display("FAIL unselected_write led=%h want=%h", led_out, manual_m); end
  endtask

  task automatic test_regs;
    logic [31:0] rd, wv;
    int rc;
    for (int i = 0; i < 4; i++) begin
      wv = $urandom;
      bus_write(5'(5'h10 + 4 * i), wv);
      pat_m[i] = wv[7:0];
    end
    for (int i = 0; i < 4; i++) begin
      bus_read(5'(5'h10 + 4 * i), rd, rc);
      checks++;
      if (rd !== {24'd0, pat_m[i]}) begin errors++; $display("FAIL pat%0d_read got=%h want=%h", i, rd, pat_m[i]); end
    end
    wv = $urandom;
    bus_write(5'h04, wv);
    bus_read(5'h04, rd, rc);
    checks++;
    if (rd !== {8'd0, wv[23:0]}) begin errors++; $display("FAIL period_read got=%h want=%h", rd, wv[23:0]); end
    wv = $urandom & 32'hFFFF_FFFE;
    bus_write(5'h00, wv);
    bus_read(5'h00, rd, rc);
    checks++;
    if (rd !== {28'd0, wv[3:0]}) begin errors++; $display("FAIL ctrl_read got=%h want=%h", rd, wv[3:0]); end
    bus_write(5'h08, 32'hFFFF_FFFF);
    bus_read(5'h08, rd, rc);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL status_ro got=%h want=0", rd); end
    checks++;
    if (led_out !== manual_m) begin errors++; $display("FAIL idle_led got=%h want=%h", led_out, manual_m); end
  endtask

  task automatic run_and_check(input string name, input int period, input int last,
                               input bit loop, input int ncyc);
    int p, j;
    logic [7:0]  exp;
    logic [31:0] rd, es;
    int rc;
    p = (period == 0) ? 1 : period;
    start_seq(period, last, loop);
    for (int i = 0; i < ncyc; i++) begin
      j = cyc - start_cyc;
      exp = pat_m[model_idx(j, p, last, loop)];
      checks++;
      if (led_out !== exp) begin
        errors++;
        $display("FAIL %s_led j=%0d got=%h want=%h", name, j, led_out, exp);
      end
      @(posedge HCLK); #1;
    end
    bus_read(5'h08, rd, rc);
    es = model_status(rc - start_cyc, p, last, loop);
    checks++;
    if (rd !== es) begin errors++; $display("FAIL %s_status got=%h want=%h", name, rd, es); end
  endtask

  task automatic test_oneshot;
    pat_m[0] = 8'h01; pat_m[1] = 8'h02; pat_m[2] = 8'h04; pat_m[3] = 8'h08;
    for (int i = 0; i < 4; i++) bus_write(5'(5'h10 + 4 * i), {24'd0, pat_m[i]});
    run_and_check("oneshot", 3, 3, 1'b0, 16);
    checks++;
    if (led_out !== 8'h08) begin errors++; $display("FAIL oneshot_hold got=%h want=08", led_out); end
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 4; i++) begin
        pat_m[i] = 8'($urandom);
        bus_write(5'(5'h10 + 4 * i), {24'($urandom), pat_m[i]});
      end
      run_and_check("oneshot_rand", $urandom_range(0, 5), $urandom_range(0, 3), 1'b0, 26);
    end
  endtask

  task automatic test_loop;
    pat_m[0] = 8'h01; pat_m[1] = 8'h02;
    bus_write(5'h10, 32'h01);
    bus_write(5'h14, 32'h02);
    run_and_check("loop", 0, 1, 1'b1, 20);
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 4; i++) begin
        pat_m[i] = 8'($urandom);
        bus_write(5'(5'h10 + 4 * i), {24'd0, pat_m[i]});
      end
      run_and_check("loop_rand", $urandom_range(1, 4), $urandom_range(0, 3), 1'b1, 30);
    end
  endtask

  task automatic test_stop;
    logic [31:0] rd;
    int rc;
    run_and_check("prestop", $urandom_range(1, 3), 3, 1'b1, $urandom_range(2, 9));
    bus_write(5'h00, 32'h0);
    checks++;
    if (led_out !== manual_m) begin errors++; $display("FAIL stop_led got=%h want=%h", led_out, manual_m); end
    bus_read(5'h08, rd, rc);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL stop_status got=%h want=0", rd); end
    bus_write(5'h00, 32'h0D);
    checks++;
    if (led_out !== pat_m[0]) begin errors++; $display("FAIL restart_led got=%h want=%h", led_out, pat_m[0]); end
    bus_write(5'h00, 32'h0);
  endtask

  task automatic test_collision;
    logic [31:0] rd;
    int rc;
    for (int i = 0; i < 4; i++) begin
      pat_m[i] = 8'h10 << i;
      bus_write(5'(5'h10 + 4 * i), {24'd0, pat_m[i]});
    end
    start_seq(4, 3, 1'b0);
    // Address phase now lands so the data phase is the expiry cycle of step 0.
    repeat (2) begin
      checks++;
      if (led_out !== pat_m[0]) begin errors++; $display("FAIL collide_pre got=%h want=%h", led_out, pat_m[0]); end
      @(posedge HCLK); #1;
    end
    bus_write(5'h00, 32'h0);
    checks++;
    if (led_out !== manual_m) begin errors++; $display("FAIL collide_led got=%h want=%h", led_out, manual_m); end
    bus_read(5'h08, rd, rc);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL collide_status got=%h want=0", rd); end
  endtask

  task automatic test_reset_midrun;
    logic [31:0] rd;
    int rc;
    bus_write(5'h0C, 32'h77);
    manual_m = 8'h77;
    start_seq(2, 3, 1'b1);
    repeat (5) @(posedge HCLK);
    #3;
    HRESET = 1'b1;
    #1;
    checks++;
    if (led_out !== 8'h00) begin errors++; $display("FAIL midrun_reset_led got=%h want=00", led_out); end
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    for (int i = 0; i < 4; i++) pat_m[i] = 8'h00;
    manual_m = 8'h00;
    bus_read(5'h08, rd, rc);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL midrun_reset_status got=%h want=0", rd); end
    bus_read(5'h04, rd, rc);
    checks++;
    if (rd !== 32'h1) begin errors++; $display("FAIL midrun_reset_period got=%h want=1", rd); end
    checks++;
    if (led_out !== 8'h00) begin errors++; $display("FAIL midrun_reset_idle got=%h want=00", led_out); end
  endtask

  initial begin
    HRESET = 1'b1; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HSIZE = 3'd2;
    HPROT = 4'd0; HWRITE = 1'b0; HWDATA = '0; HREADY = 1'b1;
    test_reset();
    test_manual();
    test_regs();
    test_oneshot();
    test_loop();
    test_stop();
    test_collision();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahblite_led_sequencer.md
# ahblite_led_sequencer

AHB-Lite slave that owns the board's 8-bit LED port and sequences it through a programmable table of four patterns at a software-set step period, with one-shot or looping playback. When idle it drives a software-written manual value, so one peripheral slot serves both direct LED control and autonomous blink/chase effects without CPU intervention. It sits on the AHB-Lite bus matrix as a zero-wait-state slave.

## Interface

- No parameters; pattern depth fixed at 4, step counter fixed at 24 bits.
- HCLK  in  1  bus clock, all logic rising-edge
- HRESET  in  1  asynchronous reset, active-high
- HSEL  in  1  slave select
- HADDR  in  32  address; only HADDR[4:2] decoded
- HTRANS  in  2  transfer type; HTRANS[1]=1 is a valid transfer
- HSIZE  in  3  ignored; all accesses treated as 32-bit
- HPROT  in  4  ignored
- HWRITE  in  1  1 = write
- HWDATA  in  32  write data (data phase)
- HREADY  in  1  bus ready
- HREADYOUT  out  1  constant 1
- HRDATA  out  32  read data (data phase)
- HRESP  out  1  constant 0
- led_out  out  8  registered LED drive

## Operation

- Address phase qualified when HSEL & HTRANS[1] & HREADY; HADDR[4:2] and HWRITE registered; write takes effect from HWDATA in the following (data) cycle.
- Register map (word offset, reset value):
  - 0x00 CTRL (0): [0] EN, [1] LOOP, [3:2] LAST (index of final table entry); others read 0.
  - 0x04 PERIOD (1): [23:0] cycles per step; 0 treated as 1.
  - 0x08 STATUS (RO): [0] BUSY, [2:1] current index, [3] DONE. Writes ignored.
  - 0x0C MANUAL (0): [7:0] LED value in IDLE.
  - 0x10–0x1C PAT0–PAT3 (0): [7:0] patterns.
- Reads return register contents zero-extended, combinationally from the registered data-phase address; non-read or unselected cycles return 0.
- FSM states IDLE, RUN, DONE; reset → IDLE.
  - IDLE: led_out ← MANUAL every cycle. CTRL write with EN=1 → RUN, idx=0, cnt=0, led_out ← PAT0.
  - RUN: cnt increments; when cnt == max(PERIOD,1)−1: cnt ← 0; if idx==LAST: LOOP=1 → idx ← 0, load PAT0; LOOP=0 → DONE, led_out holds. Else idx+1, load PAT[idx+1].
  - DONE: led_out holds last pattern, DONE=1, BUSY=0. CTRL write with EN=1 restarts as from IDLE (DONE cleared); EN=0 → IDLE.
  - Any CTRL write with EN=0 → IDLE from any state, DONE cleared, cnt/idx ← 0.
  - CTRL write with EN=1 during RUN: LOOP/LAST updated, no restart; new LAST used at next comparison. If idx > new LAST, sequence continues until idx wraps to 3 then compares (2-bit index wraps 3→0).
- BUSY = (state == RUN). STATUS index = idx.
- PAT/PERIOD writes during RUN: take effect at next step load / next count comparison; current step not restarted.

## Timing

- Zero wait states; HREADYOUT=1, HRESP=0 always, including reset.
- Reset (asynchronous assert): led_out=0, all registers to reset values, state IDLE, cnt=0, idx=0; HRDATA=0.
- Write data phase in cycle N → register and FSM update at edge ending N; led_out reflects result from cycle N+1 (PAT0 on start, MANUAL in IDLE).
- Each pattern held exactly max(PERIOD,1) cycles; PERIOD=1 changes led_out every cycle.
- Read of STATUS in cycle N returns state as of start of cycle N.
- Write to CTRL and step expiry in same cycle: CTRL write wins.

## Test plan

- Reset: assert HRESET mid-RUN → led_out=0x00, STATUS=0, PERIOD reads 1 on next read.
- Manual: write MANUAL=0xA5 → led_out=0xA5 one cycle after data phase; readback 0x000000A5.
- One-shot: PAT0..3=0x01,0x02,0x04,0x08, PERIOD=3, CTRL=0x0D (EN, LAST=3) → each value held exactly 3 cycles, then DONE, STATUS=0x08|0x6 (idx 3), led_out stays 0x08.
- Loop: PERIOD=0, CTRL=0x07 (EN, LOOP, LAST=1) → led_out alternates 0x01/0x02 every cycle indefinitely; BUSY=1.
- Stop: during RUN write CTRL=0 → next cycle led_out=MANUAL, STATUS=0; restart write CTRL=0x0D → led_out=PAT0.
- Collision: CTRL=0 write data phase coincides with step expiry → IDLE, no next pattern shown.
